keypad_scanner: RTL and testbench

Drives the 5×4 calculator keypad matrix and turns raw contact closures into debounced key events for the calculator core. It walks one active-low row strobe across `K_ROW`, samples the pulled-up `K_COL` lines after a settle interval, and confirms a press over several consecutive samples. It then reports exactly one `keyValid` pulse per press and holds `keyDown` until the release is confirmed.

---
 rtl/keypad_scanner.sv | 165 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 5x4 active-low keypad matrix and produces debounced key events.
// One row strobe at a time is pulled low; after a settle interval the
// pulled-up column lines are sampled. A press must be seen on
// DEBOUNCE_COUNT consecutive samples before it is reported, and a release
// must likewise be seen on DEBOUNCE_COUNT consecutive all-high samples.
//
// Parameters:
//   SETTLE_CYCLES  - cycles each row is driven before sampling (>= 2)
//   DEBOUNCE_COUNT - consecutive matching samples to confirm (>= 1)
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   K_COL    in   [3:0] column lines, active-low (1 = open)
//   K_ROW    out  [4:0] row strobes, active-low one-hot
//   keyCode  out  [4:0] confirmed key = row*4 + col
//   keyValid out  one-cycle pulse on press confirmation
//   keyDown  out  high from press confirmation to release confirmation
module keypad_scanner #(
  parameter int SETTLE_CYCLES  = 1000,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] K_COL,
  output logic [4:0] K_ROW,
  output logic [4:0] keyCode,
  output logic       keyValid,
  output logic       keyDown
);

  localparam int DW = $clog2(SETTLE_CYCLES);
  localparam int MW = $clog2(DEBOUNCE_COUNT + 1);

  localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
  localparam logic [MW-1:0] MATCH_DONE = MW'(DEBOUNCE_COUNT);

  localparam logic [1:0] SCAN    = 2'd0;
  localparam logic [1:0] CONFIRM = 2'd1;
  localparam logic [1:0] HELD    = 2'd2;

  logic [1:0]    state;
  logic [2:0]    row;
  logic [DW-1:0] dwell;
  logic [MW-1:0] match;
  logic [1:0]    lat_col;

  logic          sample;
  logic          col_hit;
  logic [1:0]    col_sel;
  logic [2:0]    row_next;
  logic [MW-1:0] match_inc;

  assign sample    = (dwell == DWELL_LAST);
  assign col_hit   = (K_COL != 4'hF);
  assign row_next  = (row == 3'd4) ? 3'd0 : row + 3'd1;
  assign match_inc = match + MW'(1);

  // Lowest-indexed closed column wins when several keys share a row.
  always_comb begin
    col_sel = 2'd3;
    if (!K_COL[0])      col_sel = 2'd0;
    else if (!K_COL[1]) col_sel = 2'd1;
    else if (!K_COL[2]) col_sel = 2'd2;
  end

  // Row strobe is decoded straight from the row index, so it is always
  // one-hot low and returns to row 0 the moment reset asserts.
  always_comb begin
    case (row)
      3'd0:    K_ROW = 5'b11110;
      3'd1:    K_ROW = 5'b11101;
      3'd2:    K_ROW = 5'b11011;
      3'd3:    K_ROW = 5'b10111;
      3'd4:    K_ROW = 5'b01111;
      default: K_ROW = 5'b11110;
    endcase
  end

  // The dwell counter free-runs across states; every row change happens on
  // a sample edge, so wrapping here also restarts the count for a new row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
    end else if (sample) begin
      dwell <= '0;
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SCAN;
      row      <= 3'd0;
      match    <= '0;
      lat_col  <= 2'd0;
      keyCode  <= 5'd0;
      keyValid <= 1'b0;
      keyDown  <= 1'b0;
    end else begin
      keyValid <= 1'b0;
      if (sample) begin
        case (state)
          SCAN: begin
            if (!col_hit) begin
              row <= row_next;
            end else begin
              lat_col <= col_sel;
              // With a single-sample debounce the first hit is already
              // the confirming one.
              if (DEBOUNCE_COUNT == 1) begin
                keyCode  <= {row, col_sel};
                keyValid <= 1'b1;
                keyDown  <= 1'b1;
                match    <= '0;
                state    <= HELD;
              end else begin
                match <= MW'(1);
                state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (col_hit && (col_sel == lat_col)) begin
              if (match_inc == MATCH_DONE) begin
                keyCode  <= {row, lat_col};
                keyValid <= 1'b1;
                keyDown  <= 1'b1;
                match    <= '0;
                state    <= HELD;
              end else begin
                match <= match_inc;
              end
            end else begin
              // Bounce or a different key: drop it and keep scanning.
              match <= '0;
              state <= SCAN;
              row   <= row_next;
            end
          end
          HELD: begin
            // Any closure restarts the release count, so only an unbroken
            // run of all-high samples ends the press.
            if (col_hit) begin
              match <= '0;
            end else if (match_inc == MATCH_DONE) begin
              keyDown <= 1'b0;
              match   <= '0;
              state   <= SCAN;
              row     <= row_next;
            end else begin
              match <= match_inc;
            end
          end
          default: begin
            match <= '0;
            state <= SCAN;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Self-checking bench for keypad_scanner with SETTLE_CYCLES=8 and
// DEBOUNCE_COUNT=3. A key matrix model ties K_COL to the active row strobe.
// Expected key events (press/release with code and edge number) are queued
// as stimulus is applied and compared when the DUT reports them.
module tb_keypad_scanner;

  localparam int SETTLE   = 8;
  localparam int DEBOUNCE = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  K_COL;
  logic [4:0]  K_ROW;
  logic [4:0]  keyCode;
  logic        keyValid;
  logic        keyDown;

  logic [19:0] keys;
  int          cyc;
  int          total;
  int          bad;

  typedef struct {
    bit is_press;
    int code;
    int at;
  } sb_entry_t;

  sb_entry_t expq[$];
  sb_entry_t ev;
  logic      prev_valid = 1'b0;
  logic      prev_down  = 1'b0;

  keypad_scanner #(
    .SETTLE_CYCLES (SETTLE),
    .DEBOUNCE_COUNT(DEBOUNCE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .K_COL   (K_COL),
    .K_ROW   (K_ROW),
    .keyCode (keyCode),
    .keyValid(keyValid),
    .keyDown (keyDown)
  );

  always #5 clk = ~clk;

  // Key matrix: a closed key pulls its column low while its row is strobed.
  always_comb begin
    K_COL = 4'hF;
    for (int r = 0; r < 5; r++) begin
      if (!K_ROW[r]) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4+c]) K_COL[c] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic stepTo(input int target);
    while (cyc < target) step();
  endtask

  task automatic applyStimulus(input logic [19:0] k);
    keys = k;
  endtask

  task automatic expectEvent(input bit is_press, input int code, input int at);
    sb_entry_t e;
    e.is_press = is_press;
    e.code     = code;
    e.at       = at;
    expq.push_back(e);
  endtask

  function automatic logic [19:0] key(input int r, input int c);
    logic [19:0] k;
    k = '0;
    k[r*4+c] = 1'b1;
    return k;
  endfunction

  function automatic logic [4:0] rowStrobe(input int r);
    logic [4:0] v;
    v = 5'b00001 << r;
    return ~v;
  endfunction

  // Event monitor: samples on the falling edge, reports press and release
  // events and matches them against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_down  = 1'b0;
    end else begin
      if (prev_valid) checkOutput("valid_clear", int'(keyValid), 0);
      if (keyValid && !prev_valid) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_press", int'(keyCode), -1);
        end else begin
          ev = expq.pop_front();
          checkOutput("press_kind", 1, int'(ev.is_press));
          checkOutput("press_code", int'(keyCode), ev.code);
          checkOutput("press_cycle", cyc, ev.at);
          checkOutput("press_down", int'(keyDown), 1);
        end
      end
      if (!keyDown && prev_down) begin
        if (expq.size() == 0) begin
          checkOutput("unexpected_release", cyc, -1);
        end else begin
          ev = expq.pop_front();
          checkOutput("release_kind", 0, int'(ev.is_press));
          checkOutput("release_code", int'(keyCode), ev.code);
          checkOutput("release_cycle", cyc, ev.at);
        end
      end
      prev_valid = keyValid;
      prev_down  = keyDown;
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    keys  = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_row", int'(K_ROW), int'(5'b11110));
    checkOutput("rst_code", int'(keyCode), 0);
    checkOutput("rst_valid", int'(keyValid), 0);
    checkOutput("rst_down", int'(keyDown), 0);
    rst_n = 1'b1;
    cyc   = 0;

    // Idle scan: each row strobed for 8 cycles, wrapping after row 4.
    for (int i = 0; i <= 5; i++) begin
      stepTo(8*i);
      checkOutput("idle_row_enter", int'(K_ROW), int'(rowStrobe(i % 5)));
      stepTo(8*i + 7);
      checkOutput("idle_row_hold", int'(K_ROW), int'(rowStrobe(i % 5)));
    end

    // Steady press row 2 / col 1: detected at edge 64, confirmed at 80.
    stepTo(48);
    applyStimulus(key(2, 1));
    expectEvent(1'b1, 9, 80);
    stepTo(79);
    checkOutput("down_before_confirm", int'(keyDown), 0);
    stepTo(90);
    checkOutput("held_row_a", int'(K_ROW), int'(rowStrobe(2)));
    stepTo(100);
    checkOutput("held_down", int'(keyDown), 1);
    checkOutput("held_code", int'(keyCode), 9);
    applyStimulus('0);
    expectEvent(1'b0, 9, 120);
    stepTo(119);
    checkOutput("down_until_release", int'(keyDown), 1);
    checkOutput("held_row_b", int'(K_ROW), int'(rowStrobe(2)));
    stepTo(120);
    checkOutput("row_after_release", int'(K_ROW), int'(rowStrobe(3)));

    // Bounce on row 3 / col 0: one hit then open, scan resumes at row 4.
    applyStimulus(key(3, 0));
    stepTo(128);
    applyStimulus('0);
    stepTo(130);
    checkOutput("bounce_confirm_row", int'(K_ROW), int'(rowStrobe(3)));
    stepTo(136);
    checkOutput("bounce_resume", int'(K_ROW), int'(rowStrobe(4)));
    checkOutput("bounce_down", int'(keyDown), 0);

    // Two keys on row 1: lowest column wins, code 6, confirmed at 176.
    applyStimulus(key(1, 2) | key(1, 3));
    expectEvent(1'b1, 6, 176);
    stepTo(177);
    // Row 4 key added during HELD must stay invisible.
    applyStimulus(key(1, 2) | key(1, 3) | key(4, 0));
    stepTo(180);
    // Release bounce: high at 184, 192, low at 200, high at 208, 216, 224.
    applyStimulus(key(4, 0));
    stepTo(193);
    applyStimulus(key(4, 0) | key(1, 2));
    stepTo(199);
    checkOutput("bounce_release_down", int'(keyDown), 1);
    stepTo(201);
    applyStimulus(key(4, 0));
    expectEvent(1'b0, 6, 224);
    stepTo(210);
    checkOutput("multi_held_row", int'(K_ROW), int'(rowStrobe(1)));
    stepTo(217);
    applyStimulus('0);
    stepTo(223);
    checkOutput("release_bounce_down", int'(keyDown), 1);
    stepTo(224);
    checkOutput("multi_after_row", int'(K_ROW), int'(rowStrobe(2)));
    checkOutput("multi_code_hold", int'(keyCode), 6);

    // Reset while held: press row 2 / col 1 again, confirmed at 248.
    applyStimulus(key(2, 1));
    expectEvent(1'b1, 9, 248);
    stepTo(260);
    checkOutput("pre_reset_down", int'(keyDown), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_down", int'(keyDown), 0);
    checkOutput("midrst_valid", int'(keyValid), 0);
    checkOutput("midrst_row", int'(K_ROW), int'(5'b11110));
    checkOutput("midrst_code", int'(keyCode), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    // Key still closed: row 2 detected at 24, confirmed at 40.
    expectEvent(1'b1, 9, 40);
    stepTo(50);
    applyStimulus('0);
    expectEvent(1'b0, 9, 72);
    stepTo(90);
    checkOutput("queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
